// File: rtl/fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer, its instruction BRAM
// and the decode/datapath stage.
interface fetch_sequencer_if #(
  parameter int AW = 10
);
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          stage_done;
  logic [2:0]    br_op;
  logic [15:0]   br_offset;
  logic [31:0]   reg_target;
  logic          flag_we;
  logic          zero_in;
  logic          carry_in;
  logic          sign_in;
  logic          ovf_in;
  logic [31:0]   npc;
  logic [31:0]   pc;
  logic [3:0]    flags;   // architectural flags {ovf, sign, carry, zero}, observation only
  logic          halt;
  logic          halted;

  modport master (
    output imem_addr, instr, instr_valid, npc, pc, flags, halted,
    input  imem_rdata, stage_done, br_op, br_offset, reg_target, flag_we,
           zero_in, carry_in, sign_in, ovf_in, halt
  );

  modport slave (
    input  imem_addr, instr, instr_valid, npc, pc, flags, halted,
    output imem_rdata, stage_done, br_op, br_offset, reg_target, flag_we,
           zero_in, carry_in, sign_in, ovf_in, halt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC / instruction-fetch sequencer: fetches one 32-bit word from a
// synchronous BRAM, issues it, waits for the datapath ack, resolves the
// branch from the committed flags and advances the PC. One instruction in flight.
module fetch_sequencer #(
  parameter int          AW       = 10,
  parameter int          IMEM_LAT = 1,
  parameter logic [31:0] RST_PC   = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  fetch_sequencer_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [1:0] LAT_M1 = 2'(IMEM_LAT - 1);

  logic [2:0]    state;
  logic [1:0]    wait_cnt;
  logic [31:0]   pc_q;
  logic [31:0]   tgt_q;
  logic [31:0]   instr_q;
  logic          vld_q;
  logic [3:0]    flags_q;   // {ovf, sign, carry, zero}
  logic [AW-1:0] addr_q;

  logic [31:0]   npc;
  logic [31:0]   rel_tgt;
  logic [31:0]   br_tgt;
  logic          z_eff;
  logic          c_eff;

  // Branch resolution; conditions see this instruction's own flag commit.
  always_comb begin
    npc     = pc_q + 32'd4;
    rel_tgt = npc + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
    z_eff   = bus.flag_we ? bus.zero_in  : flags_q[0];
    c_eff   = bus.flag_we ? bus.carry_in : flags_q[1];
    br_tgt  = npc;
    case (bus.br_op)
      3'd1, 3'd6: br_tgt = rel_tgt;
      3'd2:       br_tgt = z_eff  ? rel_tgt : npc;
      3'd3:       br_tgt = !z_eff ? rel_tgt : npc;
      3'd4:       br_tgt = c_eff  ? rel_tgt : npc;
      3'd5:       br_tgt = !c_eff ? rel_tgt : npc;
      3'd7:       br_tgt = bus.reg_target & 32'hFFFF_FFFC;
      default:    br_tgt = npc;
    endcase
  end

  // Sequencer FSM: FETCH -> WAIT -> ISSUE -> UPDATE -> FETCH, HALT is terminal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      pc_q     <= RST_PC;
      tgt_q    <= RST_PC;
      instr_q  <= '0;
      vld_q    <= 1'b0;
      flags_q  <= '0;
      addr_q   <= RST_PC[AW+1:2];
    end else begin
      case (state)
        S_FETCH: begin
          addr_q   <= pc_q[AW+1:2];
          wait_cnt <= LAT_M1;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            instr_q <= bus.imem_rdata;
            vld_q   <= 1'b1;
            state   <= S_ISSUE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_ISSUE: begin
          if (bus.stage_done) begin
            if (bus.flag_we)
              flags_q <= {bus.ovf_in, bus.sign_in, bus.carry_in, bus.zero_in};
            tgt_q <= br_tgt;
            vld_q <= 1'b0;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          pc_q  <= tgt_q;
          state <= bus.halt ? S_HALT : S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Address goes out straight from pc in FETCH so the BRAM samples it on
  // that edge; afterwards it is held, including across HALT.
  assign bus.imem_addr   = (state == S_FETCH) ? pc_q[AW+1:2] : addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.npc         = npc;
  assign bus.pc          = pc_q;
  assign bus.flags       = flags_q;
  assign bus.halted      = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table,
// hand-written reset/halt sequences and a randomized run against a
// behavioural model of the PC/flag rules.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_sequencer_if #(.AW(10)) bus ();

  fetch_sequencer #(.AW(10), .IMEM_LAT(1), .RST_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction BRAM, one-cycle read latency.
  logic [31:0] mem [1024];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  function automatic logic [31:0] memval(input logic [9:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0009_E377);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Bounded wait for an issued instruction, called at a negedge.
  task automatic wait_valid();
    int k = 0;
    while (!bus.instr_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("valid_timeout", 32'(bus.instr_valid), 32'd1);
  endtask

  // Ack the issued instruction; returns at the negedge inside UPDATE.
  task automatic issue(input logic [2:0] op, input logic [15:0] off, input logic [31:0] rt,
                       input logic fwe, input logic [3:0] fin);
    bus.br_op      = op;
    bus.br_offset  = off;
    bus.reg_target = rt;
    bus.flag_we    = fwe;
    {bus.ovf_in, bus.sign_in, bus.carry_in, bus.zero_in} = fin;
    bus.stage_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.stage_done = 1'b0;
    bus.flag_we    = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] off;
    logic [31:0] rt;
    logic        fwe;
    logic [3:0]  fin;        // {ovf, sign, carry, zero}
    logic [31:0] exp_next;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vt [19];

  // Plain-arithmetic reference of the next-PC rule.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [2:0] op,
                                           input logic [15:0] off, input logic [31:0] rt,
                                           input logic z, input logic c);
    logic [31:0] seq, rel;
    bit take;
    seq  = p + 32'd4;
    rel  = seq + 32'(int'($signed(off)) * 4);
    take = (op == 1) || (op == 6) || (op == 2 && z) || (op == 3 && !z) ||
           (op == 4 && c) || (op == 5 && !c);
    if (op == 7) return {rt[31:2], 2'b00};
    return take ? rel : seq;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur, m_pc;
    logic [3:0]  m_f;
    logic [9:0]  held;

    for (int i = 0; i < 1024; i++) mem[i] = memval(10'(i));
    bus.stage_done = 0; bus.br_op = 0; bus.br_offset = 0; bus.reg_target = 0;
    bus.flag_we = 0; bus.zero_in = 0; bus.carry_in = 0; bus.sign_in = 0;
    bus.ovf_in = 0; bus.halt = 0;

    vt[0]  = '{3'd0, 16'd0,    32'h0,         1'b0, 4'b0000, 32'h4,         4'b0000};
    vt[1]  = '{3'd0, 16'd0,    32'h0,         1'b0, 4'b0000, 32'h8,         4'b0000};
    vt[2]  = '{3'd0, 16'd0,    32'h0,         1'b0, 4'b0000, 32'hC,         4'b0000};
    vt[3]  = '{3'd0, 16'd0,    32'h0,         1'b0, 4'b0000, 32'h10,        4'b0000};
    vt[4]  = '{3'd1, 16'd11,   32'h0,         1'b0, 4'b0000, 32'h40,        4'b0000};
    vt[5]  = '{3'd2, 16'hFFFE, 32'h0,         1'b1, 4'b0001, 32'h3C,        4'b0001};
    vt[6]  = '{3'd1, 16'd0,    32'h0,         1'b0, 4'b0000, 32'h40,        4'b0001};
    vt[7]  = '{3'd2, 16'hFFFE, 32'h0,         1'b1, 4'b0000, 32'h44,        4'b0000};
    vt[8]  = '{3'd1, 16'd46,   32'h0,         1'b0, 4'b0000, 32'h100,       4'b0000};
    vt[9]  = '{3'd6, 16'h10,   32'h0,         1'b0, 4'b0000, 32'h144,       4'b0000};
    vt[10] = '{3'd7, 16'd0,    32'h106,       1'b0, 4'b0000, 32'h104,       4'b0000};
    vt[11] = '{3'd0, 16'd0,    32'h0,         1'b1, 4'b1110, 32'h108,       4'b1110};
    vt[12] = '{3'd0, 16'd0,    32'h0,         1'b0, 4'b0001, 32'h10C,       4'b1110};
    vt[13] = '{3'd4, 16'd4,    32'h0,         1'b0, 4'b0000, 32'h120,       4'b1110};
    vt[14] = '{3'd5, 16'd4,    32'h0,         1'b0, 4'b0000, 32'h124,       4'b1110};
    vt[15] = '{3'd3, 16'hFFFF, 32'h0,         1'b1, 4'b0000, 32'h124,       4'b0000};
    vt[16] = '{3'd7, 16'd0,    32'hFFFF_FFFF, 1'b0, 4'b0000, 32'hFFFF_FFFC, 4'b0000};
    vt[17] = '{3'd0, 16'd0,    32'h0,         1'b0, 4'b0000, 32'h0,         4'b0000};
    vt[18] = '{3'd3, 16'd3,    32'h0,         1'b0, 4'b0000, 32'h10,        4'b0000};

    // Reset values and fetch-to-valid latency.
    @(negedge clk);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_npc", bus.npc, 32'h4);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_flags", 32'(bus.flags), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("lat_valid_c1", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    chk("lat_valid_c2", 32'(bus.instr_valid), 32'h1);
    chk("lat_instr", bus.instr, memval(10'd0));

    // Directed vector table.
    cur = 32'h0;
    for (int i = 0; i < 19; i++) begin
      wait_valid();
      chk($sformatf("v%0d_pc", i), bus.pc, cur);
      chk($sformatf("v%0d_npc", i), bus.npc, cur + 32'd4);
      chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(cur[11:2]));
      chk($sformatf("v%0d_instr", i), bus.instr, memval(cur[11:2]));
      issue(vt[i].op, vt[i].off, vt[i].rt, vt[i].fwe, vt[i].fin);
      chk($sformatf("v%0d_flags", i), 32'(bus.flags), 32'(vt[i].exp_flags));
      chk($sformatf("v%0d_vld_clr", i), 32'(bus.instr_valid), 32'h0);
      cur = vt[i].exp_next;
    end

    // Halt: instruction at 0x10 retires, then nothing more is fetched.
    wait_valid();
    chk("halt_pc_issue", bus.pc, 32'h10);
    bus.halt = 1'b1;
    issue(3'd0, 16'd0, 32'h0, 1'b0, 4'b0000);
    @(negedge clk);
    bus.halt = 1'b0;
    chk("halt_halted", 32'(bus.halted), 32'h1);
    chk("halt_valid", 32'(bus.instr_valid), 32'h0);
    chk("halt_pc", bus.pc, 32'h14);
    held = bus.imem_addr;
    chk("halt_addr", 32'(held), 32'h4);
    bus.stage_done = 1'b1;
    for (int k = 0; k < 5; k++) @(negedge clk);
    bus.stage_done = 1'b0;
    chk("halt_addr_hold", 32'(bus.imem_addr), 32'(held));
    chk("halt_stays", 32'(bus.halted), 32'h1);
    chk("halt_no_valid", 32'(bus.instr_valid), 32'h0);

    // Reset asserted during WAIT aborts everything.
    do_reset();
    wait_valid();
    issue(3'd1, 16'd100, 32'h0, 1'b1, 4'b1111);
    @(negedge clk);   // FETCH
    @(negedge clk);   // WAIT
    chk("wait_pc_before", bus.pc, 32'h194);
    chk("wait_valid_low", 32'(bus.instr_valid), 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_flags", 32'(bus.flags), 32'h0);
    chk("arst_addr", 32'(bus.imem_addr), 32'h0);
    chk("arst_npc", bus.npc, 32'h4);
    @(negedge clk);
    rst = 1'b1;
    // Reset while an instruction is presented drops instr_valid at once.
    wait_valid();
    #1 rst = 1'b0;
    #1;
    chk("arst_issue_valid", 32'(bus.instr_valid), 32'h0);
    chk("arst_issue_pc", bus.pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized run against the reference model.
    m_pc = 32'h0;
    m_f  = 4'h0;
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  op;
      logic [15:0] off;
      logic [31:0] rt;
      logic        fwe;
      logic [3:0]  fin;
      int          dly;
      op  = 3'($urandom_range(0, 7));
      off = 16'($urandom);
      rt  = $urandom;
      fwe = 1'($urandom);
      fin = 4'($urandom);
      dly = $urandom_range(0, 2);
      wait_valid();
      chk("rnd_pc", bus.pc, m_pc);
      chk("rnd_instr", bus.instr, memval(m_pc[11:2]));
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        chk("rnd_hold", bus.instr, memval(m_pc[11:2]));
      end
      issue(op, off, rt, fwe, fin);
      if (fwe) m_f = fin;
      m_pc = ref_next(m_pc, op, off, rt, m_f[0], m_f[1]);
      chk("rnd_flags", 32'(bus.flags), 32'(m_f));
      if ($urandom_range(0, 3) == 0) begin
        // A stray ack outside ISSUE must be ignored.
        bus.br_op = 3'($urandom); bus.flag_we = 1'b1;
        {bus.ovf_in, bus.sign_in, bus.carry_in, bus.zero_in} = 4'($urandom);
        bus.stage_done = 1'b1;
        @(negedge clk);
        bus.stage_done = 1'b0;
        bus.flag_we = 1'b0;
        chk("rnd_stray_flags", 32'(bus.flags), 32'(m_f));
        chk("rnd_stray_pc", bus.pc, m_pc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
